// File: rtl/serial_receiver_if.sv
// Serial receiver bus: serial input side (SDI/RE), consumer handshake
// (DOUT/VALID/ACK) and status flags (BUSY/OVERRUN/PARITY_ERR).
// The master is whoever drives the stream and consumes words; the slave is the receiver.
interface serial_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  SDI;
    logic                  RE;
    logic                  ACK;
    logic [DATA_WIDTH-1:0] DOUT;
    logic                  VALID;
    logic                  BUSY;
    logic                  OVERRUN;
    logic                  PARITY_ERR;

    modport master (
        output SDI, RE, ACK,
        input  DOUT, VALID, BUSY, OVERRUN, PARITY_ERR
    );

    modport slave (
        input  SDI, RE, ACK,
        output DOUT, VALID, BUSY, OVERRUN, PARITY_ERR
    );
endinterface

// File: rtl/serial_receiver.sv
// serial_receiver: turns an MSB-first bit stream into DATA_WIDTH-bit words.
// One bit is taken on each rising CLK edge with RE=1. RE=0 pauses the frame.
// A completed word goes into a holding register with a VALID/ACK handshake.
// If a word completes while the previous one is still unacknowledged, the new
// word is dropped and OVERRUN is set. OVERRUN stays set until reset.
// Optional feature: define SERIAL_RECEIVER_PARITY_EN to add one even-parity bit
// after the data bits of each frame. The parity result is reported on PARITY_ERR.
module serial_receiver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic              CLK,
    input  logic              CLR_N,
    serial_receiver_if.slave  bus
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PAR   = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sr_q, sr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;
    logic                  perr_q, perr_d;

    // The shift register with SDI appended as the new LSB. This is the candidate word on the last data edge.
    logic [DATA_WIDTH-1:0] shifted;
    assign shifted[0] = bus.SDI;
    for (genvar gi = 1; gi < DATA_WIDTH; gi++) begin : g_shift
        assign shifted[gi] = sr_q[gi-1];
    end

`ifndef SERIAL_RECEIVER_PARITY_EN
    // Without parity, the top bit is always shifted out before anything reads it.
    logic unused_sr_msb;
    assign unused_sr_msb = sr_q[DATA_WIDTH-1];
`endif

    logic                  complete;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_perr;

    // Next-state logic: frame sequencing, word completion, handshake and flags
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        dout_d    = dout_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        perr_d    = perr_q;
        complete  = 1'b0;
        word      = shifted;
        word_perr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The starting edge already samples the MSB
                if (bus.RE) begin
                    sr_d    = shifted;
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.RE) begin
                    sr_d = shifted;
                    if (cnt_q == CW'(DATA_WIDTH - 1)) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
                        cnt_d   = CW'(DATA_WIDTH);
                        state_d = ST_PAR;
`else
                        complete = 1'b1;
                        cnt_d    = '0;
                        state_d  = ST_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
`ifdef SERIAL_RECEIVER_PARITY_EN
            ST_PAR: begin
                // The data word is already fully in sr. SDI carries the even-parity bit.
                if (bus.RE) begin
                    complete  = 1'b1;
                    word      = sr_q;
                    word_perr = ^{sr_q, bus.SDI};
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A completion edge and an ACK on the same edge hand over the new word directly
        if (complete) begin
            if (!valid_q || bus.ACK) begin
                dout_d  = word;
                valid_d = 1'b1;
                perr_d  = word_perr;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.ACK) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers. Reset discards any partial frame.
    always_ff @(posedge CLK) begin
        if (!CLR_N) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            dout_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            dout_q    <= dout_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            perr_q    <= perr_d;
        end
    end

    assign bus.DOUT       = dout_q;
    assign bus.VALID      = valid_q;
    assign bus.BUSY       = busy_q;
    assign bus.OVERRUN    = overrun_q;
    assign bus.PARITY_ERR = perr_q;

endmodule
